// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and constants for the video timing scheduler.
//   - h_state_e   : horizontal line FSM states
//   - sync_bits_t : the timing flags that travel through the latency pipe
//   - VGA_*       : 640x480@60 timing constants (used as parameter defaults)
//   - bar_rgb()   : colour-bar lookup used only by the optional test pattern
package video_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BP     = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FP     = 3'd4
    } h_state_e;

    // Flags are carried active-high; sync polarity is applied at the pins.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
    } sync_bits_t;

    // Bar index 0..7 -> {r,g,b} on/off:
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return ~{idx[1], idx[2], idx[0]};
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay
//   LAT-deep shift register that realigns timing flags with pixel data
//   returned by a source with LAT clocks of latency. LAT=0 is a wire.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears the pipe)
//     din        : W-bit flags for the current clock
//     dout       : din delayed by LAT clocks
module video_sync_delay
    import video_timing_pkg::*;
#(
    parameter int LAT = 2,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (LAT == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] pipe_q [LAT];
        logic [W-1:0] pipe_d [LAT];

        always_comb begin
            pipe_d[0] = din;
            for (int i = 1; i < LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign dout = pipe_q[LAT-1];
    end

endmodule

// File: rtl/video_timing_scheduler.sv
// video_timing_scheduler
//   Raster timing generator. A horizontal FSM (IDLE/SYNC/BP/ACTIVE/FP) walks
//   each line, a line counter walks the frame. Pixel fetches (pix_req,
//   pix_x, pix_y) are issued undelayed; hsync/vsync/de/frame_start are
//   delayed LAT clocks so they line up with the source colour returning.
//   Ports:
//     clk, rst_n            : pixel clock, asynchronous active-low reset
//     en                    : run request, sampled in IDLE and at frame wrap
//     pix_req/pix_x/pix_y   : fetch strobe and 0-based visible coordinates
//     src_r/src_g/src_b     : source colour, valid LAT clocks after pix_req
//     hsync/vsync           : syncs, active level SYNC_POL
//     de, red/green/blue    : data enable and gated output colour
//     frame_start           : one-clock pulse on the first active pixel
//     busy                  : running, including LAT clocks of pipe drain
//   Build option: define VIDEO_TIMING_TEST_PATTERN_EN to replace src_* with
//   eight vertical colour bars.
module video_timing_scheduler
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   W_RGB    = 8,
    parameter int   LAT      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_req,
    output logic [10:0]      pix_x,
    output logic [9:0]       pix_y,
    input  logic [W_RGB-1:0] src_r,
    input  logic [W_RGB-1:0] src_g,
    input  logic [W_RGB-1:0] src_b,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [W_RGB-1:0] red,
    output logic [W_RGB-1:0] green,
    output logic [W_RGB-1:0] blue,
    output logic             frame_start,
    output logic             busy
);

    localparam int          V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [10:0] H_SYNC_LAST = 11'(H_SYNC - 1);
    localparam logic [10:0] H_BP_LAST   = 11'(H_BP - 1);
    localparam logic [10:0] H_ACT_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_FP_LAST   = 11'(H_FP - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VIS_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [2:0]  LAT_L       = 3'(LAT);

    h_state_e    state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [2:0]  drain_q, drain_d;

    sync_bits_t  raw_sync;
    sync_bits_t  dly_sync;
    logic        line_vis;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            drain_q <= drain_d;
        end
    end

    // Next state. en only matters in IDLE and on the last FP clock of the
    // frame; mid-frame toggles are deliberately ignored.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = ST_SYNC;
            end
            ST_SYNC: if (h_cnt_q == H_SYNC_LAST) begin
                state_d = ST_BP;
                h_cnt_d = '0;
            end
            ST_BP: if (h_cnt_q == H_BP_LAST) begin
                state_d = ST_ACTIVE;
                h_cnt_d = '0;
            end
            ST_ACTIVE: if (h_cnt_q == H_ACT_LAST) begin
                state_d = ST_FP;
                h_cnt_d = '0;
            end
            ST_FP: if (h_cnt_q == H_FP_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                    state_d = en ? ST_SYNC : ST_IDLE;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase

        // Hold busy for LAT clocks after entering IDLE so the last flags
        // leave the delay pipe before busy drops.
        drain_d = drain_q;
        if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            drain_d = LAT_L;
        end else if (drain_q != 3'd0) begin
            drain_d = drain_q - 3'd1;
        end
    end

    // Outputs
    always_comb begin
        line_vis             = (v_cnt_q >= V_VIS_START) && (v_cnt_q < V_VIS_END);
        raw_sync.hsync       = (state_q == ST_SYNC);
        raw_sync.vsync       = (state_q != ST_IDLE) && (v_cnt_q < V_SYNC_END);
        raw_sync.de          = (state_q == ST_ACTIVE) && line_vis;
        raw_sync.frame_start = raw_sync.de && (h_cnt_q == 11'd0) && (v_cnt_q == V_VIS_START);
        pix_req              = raw_sync.de;
        pix_x                = raw_sync.de ? h_cnt_q : 11'd0;
        pix_y                = raw_sync.de ? (v_cnt_q - V_VIS_START) : 10'd0;
        busy                 = (state_q != ST_IDLE) || (drain_q != 3'd0);
    end

    video_sync_delay #(
        .LAT (LAT),
        .W   (4)
    ) u_sync_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (raw_sync),
        .dout (dly_sync)
    );

    assign hsync       = dly_sync.hsync ? SYNC_POL : ~SYNC_POL;
    assign vsync       = dly_sync.vsync ? SYNC_POL : ~SYNC_POL;
    assign de          = dly_sync.de;
    assign frame_start = dly_sync.frame_start;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [10:0] BAR_W_L = 11'(BAR_W);

    logic [10:0] bar_full;
    logic [2:0]  bar_idx;
    logic [2:0]  bar_idx_dly;
    logic [2:0]  bar_col;
    logic        unused_src;

    // Bar index follows the same LAT delay as de so colour and de align.
    always_comb begin
        bar_full = h_cnt_q / BAR_W_L;
        bar_idx  = (bar_full > 11'd7) ? 3'd7 : bar_full[2:0];
    end

    video_sync_delay #(
        .LAT (LAT),
        .W   (3)
    ) u_bar_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bar_idx),
        .dout (bar_idx_dly)
    );

    assign bar_col    = bar_rgb(bar_idx_dly);
    assign red        = {W_RGB{dly_sync.de & bar_col[2]}};
    assign green      = {W_RGB{dly_sync.de & bar_col[1]}};
    assign blue       = {W_RGB{dly_sync.de & bar_col[0]}};
    assign unused_src = ^{src_r, src_g, src_b};
`else
    assign red   = dly_sync.de ? src_r : '0;
    assign green = dly_sync.de ? src_g : '0;
    assign blue  = dly_sync.de ? src_b : '0;
`endif

endmodule

// File: tb/tb_video_timing_scheduler.sv
// tb_video_timing_scheduler
//   Two instances: u_def (640x480 defaults, LAT=2) and u_small
//   (H 4/1/2/1, V 3/1/1/1, LAT=3, 8-clock lines, 6-line frames).
module tb_video_timing_scheduler;

    localparam int LAT_D   = 2;
    localparam int LAT_S   = 3;
    localparam int S_LINE  = 8;
    localparam int S_FRAME = 48;
    localparam int S_RUN   = 4 * S_FRAME;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-parameter instance
    logic        rst_d_n, en_d;
    logic [7:0]  d_src_r, d_src_g, d_src_b;
    logic        d_pix_req, d_hsync, d_vsync, d_de, d_fs, d_busy;
    logic [10:0] d_pix_x;
    logic [9:0]  d_pix_y;
    logic [7:0]  d_red, d_green, d_blue;

    video_timing_scheduler u_def (
        .clk(clk), .rst_n(rst_d_n), .en(en_d),
        .pix_req(d_pix_req), .pix_x(d_pix_x), .pix_y(d_pix_y),
        .src_r(d_src_r), .src_g(d_src_g), .src_b(d_src_b),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .red(d_red), .green(d_green), .blue(d_blue),
        .frame_start(d_fs), .busy(d_busy)
    );

    // Small-parameter instance
    logic        rst_s_n, en_s;
    logic [7:0]  s_src_r, s_src_g, s_src_b;
    logic        s_pix_req, s_hsync, s_vsync, s_de, s_fs, s_busy;
    logic [10:0] s_pix_x;
    logic [9:0]  s_pix_y;
    logic [7:0]  s_red, s_green, s_blue;

    video_timing_scheduler #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .LAT(LAT_S)
    ) u_small (
        .clk(clk), .rst_n(rst_s_n), .en(en_s),
        .pix_req(s_pix_req), .pix_x(s_pix_x), .pix_y(s_pix_y),
        .src_r(s_src_r), .src_g(s_src_g), .src_b(s_src_b),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
        .red(s_red), .green(s_green), .blue(s_blue),
        .frame_start(s_fs), .busy(s_busy)
    );

    // Pixel source with 3 clocks of latency: colour = fetched column.
    logic [7:0] sx1, sx2, sx3;
    always @(posedge clk) begin
        sx1 <= s_pix_x[7:0];
        sx2 <= sx1;
        sx3 <= sx2;
    end
    assign s_src_r = sx3;
    assign s_src_g = 8'h5a;
    assign s_src_b = ~sx3;

    // Golden per-clock table for the small timing (bit index = position).
    logic [7:0] hs_row   = 8'b0000_0011;  // SYNC at clocks 0,1
    logic [7:0] de_row   = 8'b0111_1000;  // ACTIVE at clocks 3..6
    logic [5:0] vs_line  = 6'b00_0001;    // vsync on line 0
    logic [5:0] vis_line = 6'b01_1100;    // visible lines 2..4

    function automatic void sm_model(input int c, output logic hs, output logic vs,
                                     output logic dv, output logic fs,
                                     output int x, output int y);
        int f, ln, hc;
        hs = 1'b0; vs = 1'b0; dv = 1'b0; fs = 1'b0; x = 0; y = 0;
        if (c >= 0 && c < S_RUN) begin
            f  = c % S_FRAME;
            ln = f / S_LINE;
            hc = f % S_LINE;
            hs = hs_row[hc];
            vs = vs_line[ln];
            dv = vis_line[ln] && de_row[hc];
            fs = dv && (ln == 2) && (hc == 3);
            if (dv) begin
                x = hc - 3;
                y = ln - 2;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge right after rst/en let u_def start.
    task automatic first_hsync(output int first, output int cyc0);
        first = -1;
        cyc0  = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) cyc0 = cyc;
            if (d_hsync === 1'b0) begin
                first = n;
                break;
            end
        end
    endtask

    // Called at a negedge with hsync active; returns at the next activation.
    task automatic line_period(output int width, output int per);
        width = 1;
        per   = 1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (d_hsync !== 1'b0) break;
            width++;
            per++;
        end
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            per++;
            if (d_hsync === 1'b0) break;
        end
    endtask

    initial begin
        logic hs, vs, dv, fs;
        int   x, y, fs_cnt, preq_cnt, first, cyc0, width, per, found;

        rst_d_n = 1'b0; rst_s_n = 1'b0; en_d = 1'b0; en_s = 1'b0;
        d_src_r = 8'h33; d_src_g = 8'hcc; d_src_b = 8'h99;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_hsync", d_hsync, 1'b1);
        check("rst_vsync", d_vsync, 1'b1);
        check("rst_de", d_de, 1'b0);
        check("rst_pix_req", d_pix_req, 1'b0);
        check("rst_pix_x", d_pix_x, 0);
        check("rst_pix_y", d_pix_y, 0);
        check("rst_fs", d_fs, 1'b0);
        check("rst_busy", d_busy, 1'b0);
        check("rst_rgb", {d_red, d_green, d_blue}, 24'h0);
        check("rst_s_hsync", s_hsync, 1'b1);
        check("rst_s_busy", s_busy, 1'b0);

        rst_d_n = 1'b1; rst_s_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", d_busy, 1'b0);
        check("idle_hsync", d_hsync, 1'b1);

        // Small timing: four frames against the golden table. en drops in
        // frame 2 and comes back before the wrap (no gap), then drops in
        // frame 3 and stays low (stop after frame 3).
        fs_cnt = 0;
        preq_cnt = 0;
        en_s = 1'b1;
        for (int k = 0; k < S_RUN + 8; k++) begin
            @(negedge clk);
            sm_model(k - LAT_S, hs, vs, dv, fs, x, y);
            check("s_hsync", s_hsync, !hs);
            check("s_vsync", s_vsync, !vs);
            check("s_de", s_de, dv);
            check("s_frame_start", s_fs, fs);
`ifndef VIDEO_TIMING_TEST_PATTERN_EN
            check("s_red", s_red, dv ? (x & 255) : 0);
            check("s_green", s_green, dv ? 32'h5a : 0);
            check("s_blue", s_blue, dv ? (~x & 255) : 0);
`endif
            check("s_busy", s_busy, k < S_RUN + LAT_S);
            sm_model(k, hs, vs, dv, fs, x, y);
            check("s_pix_req", s_pix_req, dv);
            check("s_pix_x", s_pix_x, x);
            check("s_pix_y", s_pix_y, y);
            if (s_fs === 1'b1) fs_cnt++;
            if (s_pix_req === 1'b1) preq_cnt++;
            en_s = !(((k + 1) >= 2 * S_FRAME + 8 && (k + 1) < 2 * S_FRAME + 24) ||
                     (k + 1) >= 3 * S_FRAME + 8);
        end
        check("s_fs_count", fs_cnt, 4);
        check("s_pix_req_count", preq_cnt, 48);

        // Default timing: start latency, sync width, line period.
        en_d = 1'b1;
        first_hsync(first, cyc0);
        check("d_first_hsync", first, 1 + LAT_D);
        check("d_first_vsync", d_vsync, 1'b0);
        line_period(width, per);
        check("d_hsync_width", width, 96);
        check("d_line_period_0", per, 800);
        line_period(width, per);
        check("d_line_period_1", per, 800);

        // First visible line (line 35).
        found = 0;
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            if (d_pix_req === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("d_first_pix_found", found, 1);
        check("d_first_pix_clk", cyc - cyc0, 35 * 800 + 96 + 48);
        for (int i = 0; i <= 642; i++) begin
            if (i > 0) @(negedge clk);
            check("d_pix_req", d_pix_req, i < 640);
            check("d_pix_x", d_pix_x, (i < 640) ? i : 0);
            check("d_pix_y", d_pix_y, 0);
            check("d_de", d_de, (i >= 2) && (i < 642));
            check("d_frame_start", d_fs, i == 2);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            if (i == 2) check("d_rgb_px0", {d_red, d_green, d_blue}, 24'hffffff);
            if (i == 82) check("d_rgb_px80", {d_red, d_green, d_blue}, 24'hffff00);
            if (i == 641) check("d_rgb_px639", {d_red, d_green, d_blue}, 24'h000000);
`else
            check("d_rgb", {d_red, d_green, d_blue},
                  ((i >= 2) && (i < 642)) ? 24'h33cc99 : 24'h0);
`endif
        end

        // Asynchronous reset in the middle of the next active region.
        found = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (d_pix_req === 1'b1) begin
                found = 1;
                break;
            end
        end
        repeat (100) @(negedge clk);
        check("d_active_before_rst", d_pix_req, found == 1);
        #2 rst_d_n = 1'b0;
        #1;
        check("arst_hsync", d_hsync, 1'b1);
        check("arst_vsync", d_vsync, 1'b1);
        check("arst_de", d_de, 1'b0);
        check("arst_pix_req", d_pix_req, 1'b0);
        check("arst_pix_x", d_pix_x, 0);
        check("arst_pix_y", d_pix_y, 0);
        check("arst_fs", d_fs, 1'b0);
        check("arst_busy", d_busy, 1'b0);
        check("arst_rgb", {d_red, d_green, d_blue}, 24'h0);
        repeat (2) @(negedge clk);
        rst_d_n = 1'b1;

        // Restart timing matches the first start.
        first_hsync(first, cyc0);
        check("d_restart_first_hsync", first, 1 + LAT_D);
        line_period(width, per);
        check("d_restart_hsync_width", width, 96);
        check("d_restart_line_period", per, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_scheduler.md
VIDEO_TIMING_SCHEDULER -- requirements
Module: video_timing_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, active level of hsync/vsync
- W_RGB, 8, width of each colour channel
- LAT, 2, pixel-source latency in clocks, range 0..7
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst_n, in, 1, reset
- en, in, 1, run request
- pix_req, out, 1, pixel fetch strobe
- pix_x, out, 11, fetch column
- pix_y, out, 10, fetch row
- src_r / src_g / src_b, in, W_RGB each, source colour, valid LAT clocks after pix_req
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, data enable
- red / green / blue, out, W_RGB each, output colour
- frame_start, out, 1, one-clock pulse at first active pixel of a frame
- busy, out, 1, timing running
REQ-003 Reset SHALL be asynchronous and active-low, on port rst_n; the design SHALL use the single clock clk.

Function
REQ-004 Horizontal FSM SHALL have states IDLE, SYNC, BP, ACTIVE, FP, with an h_cnt counter that reloads to 0 on each transition.
REQ-005 Transitions SHALL be IDLE->SYNC when en=1, SYNC->BP after H_SYNC clocks, BP->ACTIVE after H_BP, ACTIVE->FP after H_ACTIVE, and FP->SYNC after H_FP.
REQ-006 Line period SHALL be exactly H_SYNC+H_BP+H_ACTIVE+H_FP clocks, and v_cnt SHALL increment at each FP->SYNC transition.
REQ-007 v_cnt SHALL wrap from V_SYNC+V_BP+V_ACTIVE+V_FP-1 to 0, and vsync SHALL be active for v_cnt < V_SYNC.
REQ-008 A line SHALL be visible when V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE; pix_req SHALL be 1 in ACTIVE on visible lines only.
REQ-009 pix_x and pix_y SHALL be 0-based visible coordinates, valid with pix_req, and SHALL hold 0 otherwise.
REQ-010 hsync, vsync, de and frame_start SHALL be delayed by exactly LAT clocks so they align with src_*.
REQ-011 red/green/blue SHALL equal src_* when delayed de=1 and SHALL be 0 otherwise.
REQ-012 Deasserting en SHALL let the current frame complete; at the wrap of v_cnt to 0 the FSM SHALL enter IDLE with syncs inactive.
REQ-013 If en is reasserted before the wrap, the block SHALL continue without a gap.
REQ-014 busy SHALL be 1 from IDLE exit until IDLE re-entry plus LAT clocks, so the delay pipe drains.
REQ-015 en SHALL be sampled only in IDLE and at frame wrap; toggling en mid-frame SHALL have no other effect.

Reset
REQ-016 While rst_n=0, the FSM SHALL be in IDLE, all counters and the delay pipe SHALL be 0, and hsync/vsync SHALL be at ~SYNC_POL.
REQ-017 While rst_n=0, de, pix_req, frame_start, busy, pix_x, pix_y and colour outputs SHALL be 0.
REQ-018 Assertion of rst_n=0 mid-line SHALL abort immediately with no partial pulse completed.

Configuration
REQ-019 With macro VIDEO_TIMING_TEST_PATTERN_EN defined, the block SHALL ignore src_* and output 8 vertical colour bars of H_ACTIVE/8 pixels each.
REQ-020 Bar order SHALL be white, yellow, cyan, green, magenta, red, blue, black, with channels full-scale or 0, and pix_req SHALL still be generated.
REQ-021 With VIDEO_TIMING_TEST_PATTERN_EN undefined, no pattern logic SHALL be synthesised.

Structure
REQ-022 Package video_timing_pkg SHALL hold the horizontal-state enum and the 640x480@60 timing constants.
REQ-023 The LAT-deep shift register for {hsync, vsync, de, frame_start} SHALL be sub-module video_sync_delay, with LAT=0 as a pass-through.

Verification
REQ-024 Reset then en=1 with defaults: first hsync after 1 clock, line period 800, frame 525 lines, and exactly 640x480 pix_req per frame.
REQ-025 LAT=3 with src_r driven as pix_x[7:0] delayed 3 clocks: red equals x on every de=1 clock and 0 when de=0.
REQ-026 Small params (H 4/1/2/1, V 3/1/1/1): the exact sequence of hsync/vsync/de is checked against the golden table; frame_start occurs once per frame.
REQ-027 en dropped at line 100: the frame completes to line 524, then IDLE is entered and busy falls LAT clocks later; en re-raised at line 300 causes no gap.
REQ-028 rst_n pulsed low mid-ACTIVE: all outputs are 0 and syncs are inactive asynchronously; restart timing is identical to REQ-024.
REQ-029 VIDEO_TIMING_TEST_PATTERN_EN defined: pixel 0 is FFFFFF, pixel 80 is FFFF00, and pixel 639 is 000000.
